// File: rtl/fp16_add_arbiter_pkg.sv
// fp16_arb_pkg: shared widths, the response FIFO entry and the round-robin picker
// used by the shared FP16 adder arbiter (fp16_add_arbiter).
package fp16_arb_pkg;

    localparam int FP16_W     = 16;
    localparam int FIFO_DEPTH = 2;
    // Entry fields are sized for the largest supported configuration
    // (N_REQ up to 8, tags up to 16 bits) and narrowed at the top level.
    localparam int ENT_ID_W   = 3;
    localparam int ENT_TAG_W  = 16;

    typedef struct packed {
        logic [FP16_W-1:0]    x;
        logic [ENT_ID_W-1:0]  id;
        logic [ENT_TAG_W-1:0] tag;
    } resp_ent_t;

    // Returns {found, index} of the first valid requester after ptr,
    // wrapping modulo n. The scan runs far-to-near so the nearest wins.
    function automatic logic [3:0] rr_next(
        input logic [7:0] valid,
        input logic [2:0] ptr,
        input int         n
    );
        logic [3:0] res;
        int         idx;
        res = '0;
        for (int k = 8; k >= 1; k--) begin
            idx = (int'(ptr) + k) % n;
            if (k <= n && valid[idx[2:0]]) begin
                res = {1'b1, idx[2:0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fp16_add_arbiter_if.sv
// Request/response bundle between N_REQ requesters, the arbiter and the consumer.
// master = requester/consumer side, slave = arbiter side.
interface fp16_add_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int TAG_W = 4
);
    import fp16_arb_pkg::*;

    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*FP16_W-1:0] req_a;
    logic [N_REQ*FP16_W-1:0] req_b;
    logic [N_REQ*TAG_W-1:0]  req_tag;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [FP16_W-1:0]       resp_x;
    logic [ID_W-1:0]         resp_id;
    logic [TAG_W-1:0]        resp_tag;
    logic                    busy;

    modport master (
        output req_valid, req_a, req_b, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_x, resp_id, resp_tag, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_tag, resp_ready,
        output req_ready, resp_valid, resp_x, resp_id, resp_tag, busy
    );

endinterface

// File: rtl/fp16_add_arbiter_fp16adder.sv
// fp16adder: FP16 adder, round-to-nearest-even, subnormals, inf/NaN, one register stage.
// Ports: clk, rst (sync, active low), i_a, i_b operands, o_x registered sum.
module fp16adder
    import fp16_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [FP16_W-1:0] i_a,
    input  logic [FP16_W-1:0] i_b,
    output logic [FP16_W-1:0] o_x
);

    logic [FP16_W-1:0] r_x;
    logic [FP16_W-1:0] w_x, w_l, w_s;
    logic              w_swap, w_sub, w_nan, w_inf_a, w_inf_b, w_inc;
    logic [4:0]        w_el, w_es, w_d;
    logic [13:0]       w_ml, w_ms, w_n;
    logic [27:0]       w_sh;
    logic [14:0]       w_sum;
    logic [5:0]        w_e, w_sft, w_lz;
    logic [11:0]       w_m;

    always_comb begin
        w_x     = '0;
        w_swap  = i_a[14:0] < i_b[14:0];
        w_l     = w_swap ? i_b : i_a;
        w_s     = w_swap ? i_a : i_b;
        w_nan   = (i_a[14:10] == 5'h1F && i_a[9:0] != 10'd0) ||
                  (i_b[14:10] == 5'h1F && i_b[9:0] != 10'd0);
        w_inf_a = i_a[14:0] == 15'h7C00;
        w_inf_b = i_b[14:0] == 15'h7C00;
        // Subnormals share the exponent of the smallest normal.
        w_el    = (w_l[14:10] == 5'd0) ? 5'd1 : w_l[14:10];
        w_es    = (w_s[14:10] == 5'd0) ? 5'd1 : w_s[14:10];
        w_ml    = {w_l[14:10] != 5'd0, w_l[9:0], 3'b000};
        w_d     = w_el - w_es;
        w_sh    = {w_s[14:10] != 5'd0, w_s[9:0], 3'b000, 14'd0}
                  >> ((w_d > 5'd15) ? 5'd15 : w_d);
        // Bits shifted past the guard/round pair collapse into sticky.
        w_ms    = {w_sh[27:15], w_sh[14] | (|w_sh[13:0])};
        w_sub   = w_l[15] ^ w_s[15];
        w_sum   = w_sub ? ({1'b0, w_ml} - {1'b0, w_ms})
                        : ({1'b0, w_ml} + {1'b0, w_ms});
        w_lz    = 6'd14;
        for (int i = 0; i < 14; i++) begin
            if (w_sum[i]) w_lz = 6'(13 - i);
        end
        w_e     = {1'b0, w_el};
        w_sft   = '0;
        w_n     = '0;
        if (w_sum[14]) begin
            w_n = {w_sum[14:2], w_sum[1] | w_sum[0]};
            w_e = w_e + 6'd1;
        end else begin
            // Never normalise below exponent 1: result stays subnormal.
            w_sft = (w_lz < w_e - 6'd1) ? w_lz : w_e - 6'd1;
            w_n   = w_sum[13:0] << w_sft;
            w_e   = w_e - w_sft;
        end
        w_inc   = w_n[2] & (w_n[3] | w_n[1] | w_n[0]);
        w_m     = {1'b0, w_n[13:3]} + {11'd0, w_inc};
        if (w_m[11]) begin
            w_m = w_m >> 1;
            w_e = w_e + 6'd1;
        end
        if (w_nan) begin
            w_x = 16'h7E00;
        end else if (w_inf_a && w_inf_b) begin
            w_x = (i_a[15] == i_b[15]) ? i_a : 16'h7E00;
        end else if (w_inf_a) begin
            w_x = i_a;
        end else if (w_inf_b) begin
            w_x = i_b;
        end else if (w_sum == 15'd0) begin
            w_x = {w_sub ? 1'b0 : w_l[15], 15'd0};
        end else if (w_e >= 6'd31) begin
            w_x = {w_l[15], 5'h1F, 10'd0};
        end else begin
            w_x = {w_l[15], w_m[10] ? w_e[4:0] : 5'd0, w_m[9:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) r_x <= '0;
        else      r_x <= w_x;
    end

    assign o_x = r_x;

endmodule

// File: rtl/fp16_add_arbiter.sv
// fp16_add_arbiter: round-robin share of one fp16adder among N_REQ requesters,
// 2-entry credited response FIFO. Ports: clk, rst (sync, active low), bus (slave);
// with FP16_ADD_ARB_PERF_EN defined also perf_sel, perf_grants, perf_stalls.
module fp16_add_arbiter
    import fp16_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int TAG_W = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic              clk,
    input  logic              rst,
`ifdef FP16_ADD_ARB_PERF_EN
    input  logic [ID_W-1:0]   perf_sel,
    output logic [15:0]       perf_grants,
    output logic [15:0]       perf_stalls,
`endif
    fp16_add_arbiter_if.slave bus
);

    logic              r_s1_valid;
    logic [ID_W-1:0]   r_s1_id;
    logic [TAG_W-1:0]  r_s1_tag;
    logic [ID_W-1:0]   r_rr;
    resp_ent_t         r_mem [FIFO_DEPTH];
    logic              r_wr, r_rd;
    logic [1:0]        r_cnt;

    logic [3:0]        w_pick;
    logic [ID_W-1:0]   w_grant;
    logic              w_pop, w_credit_ok, w_issue;
    logic [2:0]        w_occ;
    logic [FP16_W-1:0] w_a, w_b, w_x;
    logic [TAG_W-1:0]  w_tag;
    resp_ent_t         w_ent, w_head;

    assign w_pop       = (r_cnt != 2'd0) & bus.resp_ready;
    // Slots committed after this edge: queued, minus leaving, plus in flight.
    assign w_occ       = {1'b0, r_cnt} + {2'b0, r_s1_valid} - {2'b0, w_pop};
    assign w_credit_ok = w_occ < 3'(FIFO_DEPTH);
    assign w_pick      = rr_next(8'(bus.req_valid), 3'(r_rr), N_REQ);
    assign w_grant     = w_pick[ID_W-1:0];
    // No request is accepted while reset is held.
    assign w_issue     = rst & w_pick[3] & w_credit_ok;

    always_comb begin
        bus.req_ready = '0;
        w_a           = '0;
        w_b           = '0;
        w_tag         = '0;
        if (w_issue) begin
            bus.req_ready[w_grant] = 1'b1;
            w_a   = bus.req_a[int'(w_grant)*FP16_W +: FP16_W];
            w_b   = bus.req_b[int'(w_grant)*FP16_W +: FP16_W];
            w_tag = bus.req_tag[int'(w_grant)*TAG_W +: TAG_W];
        end
    end

    fp16adder u_add (
        .clk (clk),
        .rst (rst),
        .i_a (w_a),
        .i_b (w_b),
        .o_x (w_x)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_id    <= '0;
            r_s1_tag   <= '0;
            r_rr       <= ID_W'(N_REQ - 1);
        end else begin
            r_s1_valid <= w_issue;
            if (w_issue) begin
                r_s1_id  <= w_grant;
                r_s1_tag <= w_tag;
                r_rr     <= w_grant;
            end
        end
    end

    assign w_ent = '{x: w_x, id: ENT_ID_W'(r_s1_id), tag: ENT_TAG_W'(r_s1_tag)};

    always_ff @(posedge clk) begin
        if (r_s1_valid) r_mem[r_wr] <= w_ent;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr  <= 1'b0;
            r_rd  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            if (r_s1_valid) r_wr <= ~r_wr;
            if (w_pop)      r_rd <= ~r_rd;
            r_cnt <= r_cnt + {1'b0, r_s1_valid} - {1'b0, w_pop};
        end
    end

    assign w_head         = r_mem[r_rd];
    assign bus.resp_valid = r_cnt != 2'd0;
    assign bus.resp_x     = w_head.x;
    assign bus.resp_id    = ID_W'(w_head.id);
    assign bus.resp_tag   = TAG_W'(w_head.tag);
    assign bus.busy       = r_s1_valid | (r_cnt != 2'd0);

`ifdef FP16_ADD_ARB_PERF_EN
    logic [15:0] r_grants [N_REQ];
    logic [15:0] r_stalls;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_REQ; i++) r_grants[i] <= '0;
            r_stalls <= '0;
        end else begin
            if (w_issue && r_grants[w_grant] != 16'hFFFF) begin
                r_grants[w_grant] <= r_grants[w_grant] + 16'd1;
            end
            if ((|bus.req_valid) && !w_credit_ok && r_stalls != 16'hFFFF) begin
                r_stalls <= r_stalls + 16'd1;
            end
        end
    end

    assign perf_grants = r_grants[perf_sel];
    assign perf_stalls = r_stalls;
`endif

endmodule

// File: tb/tb_fp16_add_arbiter.sv
// Directed bench for fp16_add_arbiter: reset, latency, adder vectors,
// round-robin order, backpressure credits, mid-run reset, optional perf counters.
module tb_fp16_add_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fp16_add_arbiter_if #(.N_REQ(4), .TAG_W(4)) bus ();

`ifdef FP16_ADD_ARB_PERF_EN
    logic [1:0]  perf_sel = 2'd0;
    logic [15:0] perf_grants;
    logic [15:0] perf_stalls;
`endif

    fp16_add_arbiter #(.N_REQ(4), .TAG_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef FP16_ADD_ARB_PERF_EN
        .perf_sel    (perf_sel),
        .perf_grants (perf_grants),
        .perf_stalls (perf_stalls),
`endif
        .bus         (bus)
    );

    task automatic idle();
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_tag    = '0;
        bus.resp_ready = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid  = 4'hF;
        bus.req_a      = {4{16'h3C00}};
        bus.req_b      = {4{16'h3C00}};
        bus.resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        total++;
        if (bus.req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ready got=%b exp=0000", bus.req_ready);
        end
        total++;
        if (bus.resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid);
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy got=%b exp=0", bus.busy);
        end
        rst = 1'b1;
        idle();
    endtask

    task automatic test_single();
        @(negedge clk);
        bus.req_valid    = 4'b0001;
        bus.req_a[15:0]  = 16'h3C00;
        bus.req_b[15:0]  = 16'h4000;
        bus.req_tag[3:0] = 4'hA;
        #1;
        total++;
        if (bus.req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL single_ready got=%b exp=0001", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        total++;
        if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL single_t1 got=v%b/b%b exp=v0/b1",
                     bus.resp_valid, bus.busy);
        end
        @(negedge clk);
        #1;
        total++;
        if (bus.resp_valid !== 1'b1 || bus.resp_x !== 16'h4200 ||
            bus.resp_id !== 2'd0 || bus.resp_tag !== 4'hA) begin
            bad++;
            $display("FAIL single_t2 got=v%b x%h id%0d tag%h exp=v1 x4200 id0 tagA",
                     bus.resp_valid, bus.resp_x, bus.resp_id, bus.resp_tag);
        end
        @(negedge clk);
        #1;
        total++;
        if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL single_drain got=v%b/b%b exp=v0/b0",
                     bus.resp_valid, bus.busy);
        end
    endtask

    task automatic test_adder_vectors();
        logic [15:0] va [4];
        logic [15:0] vb [4];
        logic [15:0] vx [4];
        va[0] = 16'h3C00; vb[0] = 16'h3C00; vx[0] = 16'h4000;
        va[1] = 16'h4000; vb[1] = 16'hC000; vx[1] = 16'h0000;
        va[2] = 16'h7BFF; vb[2] = 16'h7BFF; vx[2] = 16'h7C00;
        va[3] = 16'h3C00; vb[3] = 16'hBA00; vx[3] = 16'h3400;
        for (int v = 0; v < 4; v++) begin
            @(negedge clk);
            bus.req_valid      = 4'b1000;
            bus.req_a[63:48]   = va[v];
            bus.req_b[63:48]   = vb[v];
            bus.req_tag[15:12] = 4'(v);
            @(negedge clk);
            bus.req_valid = '0;
            @(negedge clk);
            #1;
            total++;
            if (bus.resp_valid !== 1'b1 || bus.resp_x !== vx[v] ||
                bus.resp_id !== 2'd3 || bus.resp_tag !== 4'(v)) begin
                bad++;
                $display("FAIL vec%0d got=v%b x%h id%0d tag%h exp=v1 x%h id3 tag%h",
                         v, bus.resp_valid, bus.resp_x, bus.resp_id,
                         bus.resp_tag, vx[v], 4'(v));
            end
        end
    endtask

    task automatic test_round_robin();
        int e;
        do_reset();
        bus.req_a      = {4{16'h3C00}};
        bus.req_b      = {4{16'h4000}};
        bus.req_tag    = {4'hB, 4'hA, 4'h9, 4'h8};
        bus.resp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            bus.req_valid = (k < 8) ? 4'hF : 4'h0;
            #1;
            if (k < 8) begin
                total++;
                if (bus.req_ready !== 4'(1 << (k % 4))) begin
                    bad++;
                    $display("FAIL rr_grant%0d got=%b exp=%b",
                             k, bus.req_ready, 4'(1 << (k % 4)));
                end
            end
            if (k >= 2 && k < 10) begin
                e = (k - 2) % 4;
                total++;
                if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'(e) ||
                    bus.resp_tag !== 4'(e + 8) || bus.resp_x !== 16'h4200) begin
                    bad++;
                    $display("FAIL rr_resp%0d got=v%b id%0d tag%h x%h exp=v1 id%0d tag%h x4200",
                             k, bus.resp_valid, bus.resp_id, bus.resp_tag,
                             bus.resp_x, e, 4'(e + 8));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int n_acc = 0;
        do_reset();
        bus.req_a[31:16] = 16'h3C00;
        bus.req_b[31:16] = 16'h3C00;
        bus.resp_ready   = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.req_valid    = 4'b0010;
            bus.req_tag[7:4] = 4'(n_acc);
            #1;
            total++;
            if (bus.req_ready !== ((k < 2) ? 4'b0010 : 4'b0000)) begin
                bad++;
                $display("FAIL bp_ready%0d got=%b exp=%b", k, bus.req_ready,
                         (k < 2) ? 4'b0010 : 4'b0000);
            end
            if (bus.req_ready[1] === 1'b1) n_acc++;
        end
        total++;
        if (bus.resp_valid !== 1'b1 || bus.resp_tag !== 4'h0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL bp_held got=v%b tag%h b%b exp=v1 tag0 b1",
                     bus.resp_valid, bus.resp_tag, bus.busy);
        end
        @(negedge clk);
        bus.resp_ready   = 1'b1;
        bus.req_tag[7:4] = 4'h2;
        #1;
        total++;
        if (bus.req_ready !== 4'b0010 || bus.resp_tag !== 4'h0 ||
            bus.resp_id !== 2'd1) begin
            bad++;
            $display("FAIL bp_resume got=r%b tag%h id%0d exp=r0010 tag0 id1",
                     bus.req_ready, bus.resp_tag, bus.resp_id);
        end
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        total++;
        if (bus.resp_valid !== 1'b1 || bus.resp_tag !== 4'h1) begin
            bad++;
            $display("FAIL bp_second got=v%b tag%h exp=v1 tag1",
                     bus.resp_valid, bus.resp_tag);
        end
        @(negedge clk);
        #1;
        total++;
        if (bus.resp_valid !== 1'b1 || bus.resp_tag !== 4'h2 ||
            bus.resp_x !== 16'h4000) begin
            bad++;
            $display("FAIL bp_third got=v%b tag%h x%h exp=v1 tag2 x4000",
                     bus.resp_valid, bus.resp_tag, bus.resp_x);
        end
        @(negedge clk);
        #1;
        total++;
        if (bus.resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_empty got=%b exp=0", bus.resp_valid);
        end
    endtask

    task automatic test_reset_flush();
        do_reset();
        bus.req_a[15:0] = 16'h3C00;
        bus.req_b[15:0] = 16'h3C00;
        bus.resp_ready  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.req_valid = 4'b0001;
        end
        @(negedge clk);
        #1;
        total++;
        if (bus.resp_valid !== 1'b1 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL flush_pre got=v%b b%b exp=v1 b1",
                     bus.resp_valid, bus.busy);
        end
        rst = 1'b0;
        #1;
        total++;
        if (bus.req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL flush_ready got=%b exp=0000", bus.req_ready);
        end
        @(negedge clk);
        #1;
        total++;
        if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_cleared got=v%b b%b exp=v0 b0",
                     bus.resp_valid, bus.busy);
        end
        rst = 1'b1;
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            total++;
            if (bus.resp_valid !== 1'b0) begin
                bad++;
                $display("FAIL flush_stale%0d got=%b exp=0", k, bus.resp_valid);
            end
        end
    endtask

`ifdef FP16_ADD_ARB_PERF_EN
    task automatic test_perf();
        do_reset();
        bus.req_a[47:32] = 16'h3C00;
        bus.req_b[47:32] = 16'h3C00;
        bus.resp_ready   = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.req_valid = 4'b0100;
        end
        @(negedge clk);
        bus.req_valid = '0;
        repeat (3) @(negedge clk);
        bus.resp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.req_valid = 4'b0100;
        end
        @(negedge clk);
        bus.req_valid = '0;
        perf_sel      = 2'd2;
        #1;
        total++;
        if (perf_grants !== 16'd10) begin
            bad++;
            $display("FAIL perf_grants got=%0d exp=10", perf_grants);
        end
        total++;
        if (perf_stalls !== 16'd3) begin
            bad++;
            $display("FAIL perf_stalls got=%0d exp=3", perf_stalls);
        end
        perf_sel = 2'd0;
        #1;
        total++;
        if (perf_grants !== 16'd0) begin
            bad++;
            $display("FAIL perf_grants0 got=%0d exp=0", perf_grants);
        end
        bus.resp_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask
`endif

    initial begin
        idle();
        test_reset();
        test_single();
        test_adder_vectors();
        test_round_robin();
        test_backpressure();
        test_reset_flush();
`ifdef FP16_ADD_ARB_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
